// File: rtl/seq_normalizer_if.sv
// Operand/result bundle for seq_normalizer: request side (start, mode, a)
// and result side (busy, done, R, N, zero).
interface seq_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] R;
  logic [CNT_W-1:0] N;
  logic             zero;

  modport master (
    output start, mode, a,
    input  busy, done, R, N, zero
  );

  modport slave (
    input  start, mode, a,
    output busy, done, R, N, zero
  );
endinterface

// File: rtl/seq_normalizer.sv
// Bit-serial normalizer: shifts the operand left one bit per clock until it is
// normalized (leading one, or first non-redundant sign bit) and reports R and N.
module seq_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  seq_normalizer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               norm_s;

  // Signed mode stops at the first bit that differs from the sign bit.
  assign norm_s = mode_q ? (work_q[WIDTH-1] ^ work_q[WIDTH-2]) : work_q[WIDTH-1];

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    r_d     = r_q;
    n_d     = n_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          busy_d = 1'b1;
          if (bus.a == {WIDTH{1'b0}}) begin
            r_d     = {WIDTH{1'b0}};
            n_d     = {CNT_W{1'b0}};
            zero_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            work_d  = bus.a;
            mode_d  = bus.mode;
            cnt_d   = {CNT_W{1'b0}};
            zero_d  = 1'b0;
            state_d = S_SHIFT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        // The count limit doubles as the all-sign-bits stop in signed mode.
        if (norm_s || (cnt_q == CNT_MAX)) begin
          r_d     = work_q;
          n_d     = cnt_q;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          work_d = {work_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      mode_q  <= 1'b0;
      r_q     <= {WIDTH{1'b0}};
      n_q     <= {CNT_W{1'b0}};
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      r_q     <= r_d;
      n_q     <= n_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.R    = r_q;
  assign bus.N    = n_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed table, randomized operands
// against a leading-bit-count model, and control corner cases.
module tb_seq_normalizer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  seq_normalizer_if #(.WIDTH(32), .CNT_W(5)) bus ();

  seq_normalizer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        mode;
    logic [31:0] exp_r;
    logic [4:0]  exp_n;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: count leading zeros / redundant sign bits directly.
  function automatic void model(input logic [31:0] a, input logic m,
                                output logic [31:0] r, output logic [4:0] n,
                                output logic z, output int lat);
    int run;
    if (a == 32'd0) begin
      r = 32'd0; n = 5'd0; z = 1'b1; lat = 1;
    end else begin
      if (!m) begin
        run = 0;
        while (run < 32 && a[31-run] == 1'b0) run++;
      end else begin
        run = 1;
        while (run < 32 && a[31-run] == a[31]) run++;
        run = run - 1;
      end
      if (run > 31) run = 31;
      n = 5'(run);
      r = a << run;
      z = 1'b0;
      lat = run + 2;
    end
  endfunction

  // One operation; optionally pokes start with another operand mid-flight.
  task automatic run_op(input string tag, input logic [31:0] a, input logic m,
                        input logic [31:0] exp_r, input logic [4:0] exp_n,
                        input logic exp_z, input int exp_lat, input int poke_at);
    int lat;
    bit got;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.mode = m;
    @(posedge clk);
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) got = 1'b1;
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = (lat == poke_at) ? 1'b1 : 1'b0;
      bus.a     = $urandom;
      bus.mode  = 1'($urandom_range(0, 1));
    end
    if (!got) $display("FAIL %s timeout: no done after %0d cycles", tag, lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " R"}, bus.R, exp_r);
    check({tag, " N"}, {27'd0, bus.N}, {27'd0, exp_n});
    check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, exp_z});
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    vec_t vecs[10];
    logic [31:0] ra, mr;
    logic        rm, mz;
    logic [4:0]  mn;
    int          ml;
    int          dn;

    vecs[0] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 33};
    vecs[1] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0, 2};
    vecs[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd0,  1'b1, 1};
    vecs[3] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd0,  1'b1, 1};
    vecs[4] = '{32'h0000_1234, 1'b1, 32'h48D0_0000, 5'd18, 1'b0, 20};
    vecs[5] = '{32'hFFFF_FF00, 1'b1, 32'h8000_0000, 5'd23, 1'b0, 25};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b0, 33};
    vecs[7] = '{32'h0000_1234, 1'b0, 32'h91A0_0000, 5'd19, 1'b0, 21};
    vecs[8] = '{32'h4000_0000, 1'b1, 32'h4000_0000, 5'd0,  1'b0, 2};
    vecs[9] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 5'd0,  1'b0, 2};

    tests = 0; fails = 0;
    rst_n = 1'b0; bus.start = 1'b0; bus.a = 32'd0; bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset R", bus.R, 32'd0);
    check("reset N", {27'd0, bus.N}, 32'd0);
    check("reset zero", {31'd0, bus.zero}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].mode, vecs[i].exp_r,
             vecs[i].exp_n, vecs[i].exp_zero, vecs[i].exp_lat, -1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = $urandom >> $urandom_range(0, 31);
        1:       ra = ~($urandom >> $urandom_range(0, 31));
        2:       ra = $urandom;
        default: ra = ($urandom_range(0, 3) == 0) ? 32'd0 : (32'd1 << $urandom_range(0, 31));
      endcase
      rm = 1'($urandom_range(0, 1));
      model(ra, rm, mr, mn, mz, ml);
      run_op($sformatf("rnd%0d a=%h m=%0d", i, ra, rm), ra, rm, mr, mn, mz, ml, -1);
    end

    // Start pulse while shifting must be ignored.
    run_op("poke", 32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0, 33, 3);

    // Reset mid-shift clears outputs at once and yields no done.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h0000_0001; bus.mode = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort R", bus.R, 32'd0);
    check("abort N", {27'd0, bus.N}, 32'd0);
    check("abort zero", {31'd0, bus.zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("abort no done", 32'(dn), 32'd0);
    run_op("after reset", 32'h0000_1234, 1'b1, 32'h48D0_0000, 5'd18, 1'b0, 20, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
